// File: rtl/fpdiv.sv
// IEEE-754 single-precision divider: multi-cycle restoring divide, truncating rounding.
// IDLE -> UNPACK -> (DONE | DIVIDE x25 -> NORM -> DONE); special operands resolve in UNPACK.
module fpdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] oprA,
  input  logic [31:0] oprB,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result
);

  // state  | meaning
  // IDLE   | waiting for start
  // UNPACK | classify operands, resolve specials or load divider
  // DIVIDE | one restoring quotient bit per cycle, 25 cycles
  // NORM   | normalise quotient, range check, pack result
  // DONE   | result valid, one-cycle done pulse
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, DONE} state_t;

  state_t             state, state_nxt;
  logic        [31:0] a_q, b_q;
  logic        [24:0] rem, q;
  logic        [23:0] mb;
  logic signed [9:0]  exp_q;
  logic        [4:0]  cnt;
  logic               sign_q;
  logic               busy_nxt, done_nxt;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, sgn;
  logic [31:0] special_res;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign sgn    = a_q[31] ^ b_q[31];
  assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
  // denormals fall in with zero here
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    special_res = {sgn, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      special_res = 32'h7fc00000;
    else if (a_inf || b_zero)
      special_res = {sgn, 8'hff, 23'd0};
  end

  logic        [24:0] diff;
  logic signed [9:0]  exp_n;
  logic        [22:0] frac_n;
  logic        [31:0] norm_res;

  assign diff = rem - {1'b0, mb};

  always_comb begin
    frac_n = q[22:0];
    exp_n  = exp_q - 10'sd1;
    if (q[24]) begin
      frac_n = q[23:1];
      exp_n  = exp_q;
    end
    norm_res = {sign_q, exp_n[7:0], frac_n};
    if (exp_n >= 10'sd255)
      norm_res = {sign_q, 8'hff, 23'd0};
    else if (exp_n <= 10'sd0)
      norm_res = {sign_q, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'd0) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = start ? UNPACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the next state so they are registered alongside it
  always_comb begin
    busy_nxt = (state_nxt == UNPACK) || (state_nxt == DIVIDE) || (state_nxt == NORM);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      rem    <= 25'd0;
      q      <= 25'd0;
      mb     <= 24'd0;
      exp_q  <= 10'sd0;
      cnt    <= 5'd0;
      sign_q <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q <= oprA;
            b_q <= oprB;
          end
        end
        UNPACK: begin
          sign_q <= sgn;
          if (special) begin
            Result <= special_res;
          end else begin
            rem   <= {2'b01, fa};
            mb    <= {1'b1, fb};
            exp_q <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
            q     <= 25'd0;
            cnt   <= 5'd24;
          end
        end
        DIVIDE: begin
          if (rem >= {1'b0, mb}) begin
            rem <= {diff[23:0], 1'b0};
            q   <= {q[23:0], 1'b1};
          end else begin
            rem <= {rem[23:0], 1'b0};
            q   <= {q[23:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        NORM:    Result <= norm_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv.sv
// Scoreboard bench for fpdiv: stimulus pushes expected results, a negedge monitor checks them.
module tb_fpdiv;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] oprA, oprB;
  logic        busy, done;
  logic [31:0] Result;

  fpdiv dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .oprA   (oprA),
    .oprB   (oprB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done=1 Result=%08h, expected no done", Result);
      end else begin
        e = sb.pop_front();
        if (Result !== e.res) begin
          fails++;
          $display("FAIL %s result: got %08h, expected %08h", e.name, Result, e.res);
        end
        tests++;
        if (cyc - e.acc != e.lat) begin
          fails++;
          $display("FAIL %s latency: got %0d, expected %0d", e.name, cyc - e.acc, e.lat);
        end
      end
      tests++;
      if (prev_done) begin
        fails++;
        $display("FAIL done_width: got done high two cycles, expected one");
      end
    end
    prev_done = done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, got, want);
    end
  endtask

  task automatic wait_empty(input string name);
    int waited = 0;
    while (sb.size() != 0 && waited < 60) begin
      @(negedge clk); #1;
      waited++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no done in 60 cycles, expected done", name);
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input int lat, input bit glitch);
    int   waited = 0;
    logic busy_ok = 1'b1;
    @(negedge clk);
    oprA = a;
    oprB = b;
    start = 1'b1;
    sb.push_back('{want, cyc + 1, lat, name});
    @(negedge clk);
    start = 1'b0;
    oprA = $urandom;
    oprB = $urandom;
    #1;
    while (sb.size() != 0 && waited < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      start = glitch && (waited == 4);
      if (start) begin
        oprA = 32'h3f800000;
        oprB = 32'h3f800000;
      end
      waited++;
      #1;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no done in 60 cycles, expected done", name);
      sb.delete();
    end
    if (busy) busy_ok = 1'b0;
    check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    oprA  = 32'd0;
    oprB  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", Result, 32'd0);
    reset = 1'b0;

    run("six_div_two",  32'h40c00000, 32'h40000000, 32'h40400000, 27, 1'b0);
    run("neg_six_div_two", 32'hc0c00000, 32'h40000000, 32'hc0400000, 27, 1'b0);
    run("one_third",    32'h3f800000, 32'h40400000, 32'h3eaaaaaa, 27, 1'b0);
    run("one_div_one",  32'h3f800000, 32'h3f800000, 32'h3f800000, 27, 1'b0);
    run("neg_div_zero", 32'hbf800000, 32'h00000000, 32'hff800000, 1, 1'b0);
    run("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7fc00000, 1, 1'b0);
    run("inf_div_inf",  32'h7f800000, 32'h7f800000, 32'h7fc00000, 1, 1'b0);
    run("nan_input",    32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1, 1'b0);
    run("one_div_neginf", 32'h3f800000, 32'hff800000, 32'h80000000, 1, 1'b0);
    run("overflow",     32'h7f000000, 32'h3e800000, 32'h7f800000, 27, 1'b0);
    run("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 27, 1'b0);
    run("denormal_in",  32'h00400000, 32'h3f800000, 32'h00000000, 1, 1'b0);
    run("start_ignored", 32'h40c00000, 32'h40000000, 32'h40400000, 27, 1'b1);

    // back-to-back: second start lands in the DONE cycle of the first
    begin
      int waited = 0;
      @(negedge clk);
      oprA = 32'h41200000;
      oprB = 32'h40000000;
      start = 1'b1;
      sb.push_back('{32'h40a00000, cyc + 1, 27, "b2b_first"});
      @(negedge clk);
      start = 1'b0;
      while (!done && waited < 60) begin
        @(negedge clk);
        waited++;
      end
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL b2b_first timeout: got no done, expected done");
      end
      oprA = 32'h3f800000;
      oprB = 32'h40400000;
      start = 1'b1;
      sb.push_back('{32'h3eaaaaaa, cyc + 1, 27, "b2b_second"});
      @(negedge clk);
      start = 1'b0;
      check("b2b_done_drop", {31'd0, done}, 32'd0);
      check("b2b_busy_rise", {31'd0, busy}, 32'd1);
      wait_empty("b2b_second");
    end

    // reset sampled at edge 10 of an in-flight divide
    @(negedge clk);
    oprA = 32'h40c00000;
    oprB = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", Result, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run("after_reset", 32'h40c00000, 32'h40000000, 32'h40400000, 27, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
